bit_select_serializer: RTL and testbench

- Parametrised successor to the fixed 16:1 MSB-first bit selector. It selects one bit from a 2**SEL_W-bit word.
- Index 0 addresses the MSB; index N-1 addresses the LSB.
- Two modes:
  - single-bit registered select;
  - serial burst, which streams a run of consecutive indices out one bit per handshake.
- Used for CSR/immediate bit extraction and for serial debug readout, behind valid/ready handshakes on both sides.

---
 rtl/bit_select_serializer_if.sv | 41 ++++
 rtl/bit_select_serializer.sv | 129 ++++++++++++
 tb/tb_bit_select_serializer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bit_select_serializer_if.sv
// Request/beat interface for bit_select_serializer: request channel in, serial bit beats out.
// The out_parity signal exists only when BIT_SELECT_SERIALIZER_PARITY_EN is defined.
interface bit_select_serializer_if #(
  parameter int SEL_W = 4
);
  localparam int N = 1 << SEL_W;

  logic             req_valid;
  logic             req_ready;
  logic             req_mode;
  logic [SEL_W-1:0] req_select;
  logic [SEL_W-1:0] req_len;
  logic [N-1:0]     req_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [SEL_W-1:0] out_index;
  logic             out_last;
  logic             busy;
`ifdef BIT_SELECT_SERIALIZER_PARITY_EN
  logic             out_parity;

  modport master (
    output req_valid, req_mode, req_select, req_len, req_data, out_ready,
    input  req_ready, out_valid, out_bit, out_index, out_last, busy, out_parity
  );
  modport slave (
    input  req_valid, req_mode, req_select, req_len, req_data, out_ready,
    output req_ready, out_valid, out_bit, out_index, out_last, busy, out_parity
  );
`else
  modport master (
    output req_valid, req_mode, req_select, req_len, req_data, out_ready,
    input  req_ready, out_valid, out_bit, out_index, out_last, busy
  );
  modport slave (
    input  req_valid, req_mode, req_select, req_len, req_data, out_ready,
    output req_ready, out_valid, out_bit, out_index, out_last, busy
  );
`endif
endinterface

// File: rtl/bit_select_serializer.sv
// MSB-first bit selector / serial burst reader over a 2**SEL_W-bit word.
// Optional parity output enabled by defining BIT_SELECT_SERIALIZER_PARITY_EN.
module bit_select_serializer #(
  parameter int SEL_W = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  bit_select_serializer_if.slave bus
);
  localparam int N = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     data_reg, data_next;
  logic [SEL_W-1:0] index_reg, index_next;
  logic [SEL_W-1:0] remain_reg, remain_next;
  logic             valid_reg, valid_next;
  logic             bit_reg, bit_next;
  logic             last_reg, last_next;
  logic             acc_reg, acc_next;
  logic             parity_reg, parity_next;

  logic [N-1:0]     req_rev;
  logic [N-1:0]     data_rev;
  logic [SEL_W-1:0] index_inc;
  logic             xfer;
  logic             first_last;

  // Bit-reversed copies so that index 0 addresses the MSB with a plain lookup.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rev
      assign req_rev[gi]  = bus.req_data[N-1-gi];
      assign data_rev[gi] = data_reg[N-1-gi];
    end
  endgenerate

  assign index_inc  = index_reg + SEL_W'(1);
  assign xfer       = valid_reg && bus.out_ready;
  assign first_last = !bus.req_mode || (bus.req_len == '0);

  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    index_next  = index_reg;
    remain_next = remain_reg;
    valid_next  = valid_reg;
    bit_next    = bit_reg;
    last_next   = last_reg;
    acc_next    = acc_reg;
    parity_next = parity_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          state_next  = bus.req_mode ? BURST : SINGLE;
          data_next   = bus.req_data;
          index_next  = bus.req_select;
          remain_next = bus.req_len;
          valid_next  = 1'b1;
          bit_next    = req_rev[bus.req_select];
          last_next   = first_last;
          acc_next    = 1'b0;
          parity_next = first_last ? req_rev[bus.req_select] : 1'b0;
        end
      end
      SINGLE, BURST: begin
        if (xfer) begin
          if (last_reg) begin
            state_next  = IDLE;
            valid_next  = 1'b0;
            last_next   = 1'b0;
            parity_next = 1'b0;
          end else begin
            // Index wraps N-1 -> 0 through natural SEL_W-bit overflow.
            index_next  = index_inc;
            bit_next    = data_rev[index_inc];
            remain_next = remain_reg - SEL_W'(1);
            last_next   = (remain_reg == SEL_W'(1));
            acc_next    = acc_reg ^ bit_reg;
            parity_next = (remain_reg == SEL_W'(1)) ?
                          (acc_reg ^ bit_reg ^ data_rev[index_inc]) : 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      data_reg   <= '0;
      index_reg  <= '0;
      remain_reg <= '0;
      valid_reg  <= 1'b0;
      bit_reg    <= 1'b0;
      last_reg   <= 1'b0;
      acc_reg    <= 1'b0;
      parity_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      index_reg  <= index_next;
      remain_reg <= remain_next;
      valid_reg  <= valid_next;
      bit_reg    <= bit_next;
      last_reg   <= last_next;
      acc_reg    <= acc_next;
      parity_reg <= parity_next;
    end
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out_valid = valid_reg;
  assign bus.out_bit   = bit_reg;
  assign bus.out_index = index_reg;
  assign bus.out_last  = last_reg;
`ifdef BIT_SELECT_SERIALIZER_PARITY_EN
  assign bus.out_parity = parity_reg;
`else
  logic unused_parity;
  assign unused_parity = acc_reg ^ parity_reg;
`endif
endmodule

// File: tb/tb_bit_select_serializer.sv
// Directed-vector bench for bit_select_serializer: single select, burst, wrap,
// backpressure, mid-burst reset and (when enabled) parity.
module tb_bit_select_serializer;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   xfer_cnt;

  bit_select_serializer_if #(.SEL_W(4)) bus ();

  bit_select_serializer #(.SEL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) xfer_cnt <= xfer_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic mode, input logic [3:0] sel, input logic [3:0] len,
                      input logic [15:0] data);
    @(negedge clk);
    chk("accept_ready", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_mode   = mode;
    bus.req_select = sel;
    bus.req_len    = len;
    bus.req_data   = data;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_data   = 16'h0000;
    bus.req_select = 4'd0;
  endtask

  // exp_bits[15-i] is the expected bit of beat i; out_ready is held at 1.
  task automatic beats(input string tag, input int n, input logic [3:0] first,
                       input logic [15:0] exp_bits, input logic exp_par);
    logic [3:0] idx;
    idx = first;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_index"}, bus.out_index, idx);
      chk({tag, "_bit"},   bus.out_bit, exp_bits[15-i]);
      chk({tag, "_last"},  bus.out_last, (i == n - 1) ? 1 : 0);
`ifdef BIT_SELECT_SERIALIZER_PARITY_EN
      chk({tag, "_parity"}, bus.out_parity, (i == n - 1) ? exp_par : 1'b0);
`endif
      idx = idx + 4'd1;
    end
    @(negedge clk);
    chk({tag, "_done_valid"}, bus.out_valid, 0);
    chk({tag, "_done_ready"}, bus.req_ready, 1);
    $display("%s: %0d beats from index %0d checked", tag, n, first);
  endtask

  initial begin
    int start_cnt;
    n_vec = 0;
    n_err = 0;
    xfer_cnt = 0;
    rst_n = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_mode   = 1'b0;
    bus.req_select = 4'd0;
    bus.req_len    = 4'd0;
    bus.req_data   = 16'h0000;
    bus.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_bit",   bus.out_bit, 0);
    chk("rst_index", bus.out_index, 0);
    chk("rst_last",  bus.out_last, 0);
`ifdef BIT_SELECT_SERIALIZER_PARITY_EN
    chk("rst_parity", bus.out_parity, 0);
`endif
    $display("reset state checked");

    // Single selects on 16'h8001
    send(1'b0, 4'd0, 4'd5, 16'h8001);
    @(negedge clk);
    chk("single0_busy", bus.busy, 1);
    chk("single0_ready", bus.req_ready, 0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("single0_hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    #0;
    chk("single0_index", bus.out_index, 0);
    chk("single0_bit",   bus.out_bit, 1);
    chk("single0_last",  bus.out_last, 1);
    @(negedge clk);
    chk("single0_done", bus.out_valid, 0);
    $display("single select=0 checked");
    send(1'b0, 4'd15, 4'd0, 16'h8001);
    beats("single15", 1, 4'd15, 16'h8000, 1'b1);
    send(1'b0, 4'd1, 4'd0, 16'h8001);
    beats("single1", 1, 4'd1, 16'h0000, 1'b0);

    // Burst and wrap
    send(1'b1, 4'd0, 4'd7, 16'hA5F0);
    beats("burst8", 8, 4'd0, 16'hA500, 1'b0);
    send(1'b1, 4'd14, 4'd3, 16'h0003);
    beats("wrap", 4, 4'd14, 16'hC000, 1'b0);

    // Backpressure at beat 4, with a competing request held during the stall
    start_cnt = xfer_cnt;
    send(1'b1, 4'd0, 4'd15, 16'hFFFF);
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      chk("bp_index", bus.out_index, b);
      chk("bp_bit",   bus.out_bit, 1);
      chk("bp_last",  bus.out_last, (b == 15) ? 1 : 0);
      if (b == 4) begin
        bus.out_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_mode   = 1'b0;
        bus.req_select = 4'd3;
        bus.req_data   = 16'h0000;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("bp_stall_valid", bus.out_valid, 1);
          chk("bp_stall_index", bus.out_index, 4);
          chk("bp_stall_bit",   bus.out_bit, 1);
          chk("bp_stall_ready", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk("bp_done_valid", bus.out_valid, 0);
    chk("bp_xfers", xfer_cnt - start_cnt, 16);
    $display("backpressure burst: %0d transfers", xfer_cnt - start_cnt);

    // Reset during beat 3 of an 8-beat burst
    send(1'b1, 4'd0, 4'd7, 16'hA5F0);
    repeat (4) @(negedge clk);
    chk("mid_index_before", bus.out_index, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy",  bus.busy, 0);
    chk("mid_rst_ready", bus.req_ready, 1);
    chk("mid_rst_index", bus.out_index, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("mid-burst reset checked");
    send(1'b0, 4'd15, 4'd0, 16'h0001);
    beats("post_rst", 1, 4'd15, 16'h8000, 1'b1);

`ifdef BIT_SELECT_SERIALIZER_PARITY_EN
    send(1'b1, 4'd0, 4'd7, 16'hA5F0);
    beats("par_len7", 8, 4'd0, 16'hA500, 1'b0);
    send(1'b1, 4'd0, 4'd2, 16'hA5F0);
    beats("par_len2", 3, 4'd0, 16'hA000, 1'b0);
    send(1'b1, 4'd0, 4'd0, 16'hA5F0);
    beats("par_len0", 1, 4'd0, 16'h8000, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
